ps2_scancode_decoder: RTL and testbench

- Sits directly downstream of ps2ctrlr and consumes its received PS/2 set-2 bytes.
- Assembles complete key events by resolving the E0 (extended), F0 (break) and E1 (pause) prefix sequences.
- Tracks Shift and Caps Lock state, translates printable keys to ASCII, and presents one event at a time on a valid/ready output register.
- Feeds LED/LCD display logic on the DE2 top level.

---
 rtl/ps2_pkg.sv | 46 ++++
 rtl/ps2_ascii_lut.sv | 56 +++++
 rtl/ps2_scancode_decoder.sv | 163 ++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ============================================================================
// ps2_pkg : shared types and constants for the PS/2 set-2 scan code decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EXT    = 3'd1,
    BRK    = 3'd2,
    EXTBRK = 3'd3,
    SKIP   = 3'd4
  } ps2_state_t;

  localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_SC_LSHIFT  = 8'h12;
  localparam logic [7:0] PS2_SC_RSHIFT  = 8'h59;
  localparam logic [7:0] PS2_SC_CAPS    = 8'h58;

  // Controller status bytes that never form part of a key event
  localparam logic [7:0] PS2_DISC_BAT    = 8'hAA;
  localparam logic [7:0] PS2_DISC_ACK    = 8'hFA;
  localparam logic [7:0] PS2_DISC_RESEND = 8'hFE;
  localparam logic [7:0] PS2_DISC_ERR0   = 8'h00;
  localparam logic [7:0] PS2_DISC_ERR1   = 8'hFF;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic [7:0] ascii;
  } ps2_event_t;

  function automatic logic ps2_is_discard(input logic [7:0] c);
    return (c == PS2_DISC_BAT)    || (c == PS2_DISC_ACK)  ||
           (c == PS2_DISC_RESEND) || (c == PS2_DISC_ERR0) ||
           (c == PS2_DISC_ERR1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_ascii_lut.sv
// ============================================================================
// ps2_ascii_lut : combinational set-2 scan code to ASCII translation
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       shift_i,
  input  logic       caps_i,
  output logic [7:0] ascii_o
);

  logic [7:0] letter;

  always_comb begin
    letter  = 8'h00;
    ascii_o = 8'h00;
    case (code_i)
      8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
      8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
      8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
      // Digit row: shifted values follow the US layout symbol row
      8'h45: ascii_o = shift_i ? 8'h29 : 8'h30;
      8'h16: ascii_o = shift_i ? 8'h21 : 8'h31;
      8'h1E: ascii_o = shift_i ? 8'h40 : 8'h32;
      8'h26: ascii_o = shift_i ? 8'h23 : 8'h33;
      8'h25: ascii_o = shift_i ? 8'h24 : 8'h34;
      8'h2E: ascii_o = shift_i ? 8'h25 : 8'h35;
      8'h36: ascii_o = shift_i ? 8'h5E : 8'h36;
      8'h3D: ascii_o = shift_i ? 8'h26 : 8'h37;
      8'h3E: ascii_o = shift_i ? 8'h2A : 8'h38;
      8'h46: ascii_o = shift_i ? 8'h28 : 8'h39;
      8'h29: ascii_o = 8'h20;
      8'h5A: ascii_o = 8'h0D;
      8'h66: ascii_o = 8'h08;
      8'h0D: ascii_o = 8'h09;
      8'h76: ascii_o = 8'h1B;
      default: ascii_o = 8'h00;
    endcase
    if (letter != 8'h00) begin
      ascii_o = (shift_i ^ caps_i) ? (letter - 8'h20) : letter;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_scancode_decoder.sv
// ============================================================================
// ps2_scancode_decoder : resolves E0/F0/E1 prefixes into key events with
// Shift/Caps tracking and ASCII translation on a valid/ready register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int PAUSE_SKIP = 7
) (
  input  logic       CLOCK_50,
  input  logic       clr,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic [7:0] ev_ascii,
  output logic       shift_held,
  output logic       caps_lock,
  output logic       overflow
);

  localparam int CNT_W = $clog2(PAUSE_SKIP + 2);

  ps2_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ps2_event_t       ev_q, ev_d;
  logic             ev_valid_q;
  logic             overflow_q;
  logic             shift_l_q, shift_r_q;
  logic             caps_q, caps_held_q;

  logic             done;
  logic             done_brk;
  logic             done_ext;
  logic [7:0]       lut_ascii;

  ps2_ascii_lut u_lut (
    .code_i  (code_in),
    .shift_i (shift_l_q | shift_r_q),
    .caps_i  (caps_q),
    .ascii_o (lut_ascii)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    done_brk = 1'b0;
    done_ext = 1'b0;
    if (code_valid) begin
      case (state_q)
        IDLE: begin
          if (code_in == PS2_PFX_EXT) begin
            state_d = EXT;
          end else if (code_in == PS2_PFX_BRK) begin
            state_d = BRK;
          end else if (code_in == PS2_PFX_PAUSE) begin
            if (PAUSE_SKIP > 0) begin
              state_d = SKIP;
              cnt_d   = CNT_W'(PAUSE_SKIP);
            end
          end else if (!ps2_is_discard(code_in)) begin
            done = 1'b1;
          end
        end
        EXT: begin
          if (code_in == PS2_PFX_BRK) begin
            state_d = EXTBRK;
          end else if (code_in != PS2_PFX_EXT) begin
            done     = 1'b1;
            done_ext = 1'b1;
            state_d  = IDLE;
          end
        end
        BRK: begin
          done     = 1'b1;
          done_brk = 1'b1;
          state_d  = IDLE;
        end
        EXTBRK: begin
          done     = 1'b1;
          done_brk = 1'b1;
          done_ext = 1'b1;
          state_d  = IDLE;
        end
        SKIP: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    ev_d.code  = code_in;
    ev_d.brk   = done_brk;
    ev_d.ext   = done_ext;
    ev_d.ascii = (done_brk || done_ext) ? 8'h00 : lut_ascii;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ev_q        <= '0;
      ev_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (done) begin
        if (!ev_valid_q || ev_ready) begin
          ev_q       <= ev_d;
          ev_valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
        // Modifiers follow every completed event, even one that was dropped
        if (!done_ext) begin
          case (code_in)
            PS2_SC_LSHIFT: shift_l_q <= ~done_brk;
            PS2_SC_RSHIFT: shift_r_q <= ~done_brk;
            PS2_SC_CAPS: begin
              if (done_brk) begin
                caps_held_q <= 1'b0;
              end else if (!caps_held_q) begin
                caps_q      <= ~caps_q;
                caps_held_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end else if (ev_valid_q && ev_ready) begin
        ev_valid_q <= 1'b0;
      end
    end
  end

  assign ev_valid   = ev_valid_q;
  assign ev_code    = ev_q.code;
  assign ev_break   = ev_q.brk;
  assign ev_ext     = ev_q.ext;
  assign ev_ascii   = ev_q.ascii;
  assign shift_held = shift_l_q | shift_r_q;
  assign caps_lock  = caps_q;
  assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scancode_decoder.sv
// ============================================================================
// tb_ps2_scancode_decoder : scenario tasks plus randomized bytes against a
// prefix-flag reference model with table-driven ASCII lookup.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ps2_scancode_decoder;

  localparam int PAUSE_SKIP = 7;

  logic       CLOCK_50 = 1'b0;
  logic       clr;
  logic [7:0] code_in;
  logic       code_valid;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;
  logic [7:0] ev_ascii;
  logic       shift_held;
  logic       caps_lock;
  logic       overflow;

  ps2_scancode_decoder #(.PAUSE_SKIP(PAUSE_SKIP)) dut (
    .CLOCK_50   (CLOCK_50),
    .clr        (clr),
    .code_in    (code_in),
    .code_valid (code_valid),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_break   (ev_break),
    .ev_ext     (ev_ext),
    .ev_ascii   (ev_ascii),
    .shift_held (shift_held),
    .caps_lock  (caps_lock),
    .overflow   (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic [7:0] ascii;
  } tb_ev_t;

  int checks   = 0;
  int failures = 0;

  tb_ev_t exp_q[$];
  tb_ev_t got_q[$];

  bit m_ext, m_brk, m_shl, m_shr, m_caps, m_caps_held;
  int m_skip;

  localparam logic [7:0] LET_SC [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIG_SC [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] DIG_SYM [10] = '{
    8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};
  localparam logic [7:0] POOL [24] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h16, 8'h1E, 8'h45, 8'h12, 8'h59, 8'h58,
    8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'hF0, 8'hF0, 8'hE0, 8'hE0, 8'hAA,
    8'hFA, 8'h75, 8'hE1, 8'h4D};

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit sh, input bit cp);
    for (int i = 0; i < 26; i++)
      if (c == LET_SC[i]) return ((sh ^ cp) ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (c == DIG_SC[i]) return sh ? DIG_SYM[i] : 8'h30 + 8'(i);
    case (c)
      8'h29:   return 8'h20;
      8'h5A:   return 8'h0D;
      8'h66:   return 8'h08;
      8'h0D:   return 8'h09;
      8'h76:   return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_skip = 0;
    m_shl = 0; m_shr = 0; m_caps = 0; m_caps_held = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    tb_ev_t e;
    bit     emit;
    e    = '0;
    emit = 0;
    if (m_skip > 0) begin
      m_skip--;
    end else if (m_brk) begin
      emit = 1; e.brk = 1; e.ext = m_ext;
      m_brk = 0; m_ext = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin emit = 1; e.ext = 1; m_ext = 0; end
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) m_skip = PAUSE_SKIP;
    else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF})) emit = 1;

    if (emit) begin
      e.code  = b;
      e.ascii = (e.brk || e.ext) ? 8'h00 : ref_ascii(b, m_shl | m_shr, m_caps);
      exp_q.push_back(e);
      if (!e.ext) begin
        if (b == 8'h12) m_shl = !e.brk;
        if (b == 8'h59) m_shr = !e.brk;
        if (b == 8'h58) begin
          if (e.brk) m_caps_held = 0;
          else if (!m_caps_held) begin m_caps = !m_caps; m_caps_held = 1; end
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLOCK_50);
    code_in    = b;
    code_valid = 1'b1;
    model_byte(b);
    @(negedge CLOCK_50);
    code_valid = 1'b0;
    code_in    = 8'($urandom);
  endtask

  // Accepted-event monitor: sample between edges when a handshake is pending
  initial begin
    forever begin
      @(negedge CLOCK_50);
      #1;
      if (clr && ev_valid && ev_ready)
        got_q.push_back(tb_ev_t'({ev_code, ev_break, ev_ext, ev_ascii}));
    end
  end

  task automatic test_reset();
    clr = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    #2;
    checks++;
    if ({ev_valid, ev_code, ev_break, ev_ext, ev_ascii, shift_held, caps_lock, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {ev_valid, ev_code, ev_break, ev_ext, ev_ascii, shift_held, caps_lock, overflow});
    end
    @(negedge CLOCK_50);
    clr = 1'b1;
    model_reset();
    send_byte(8'h12);
    send_byte(8'hE0);
    @(negedge CLOCK_50);
    clr = 1'b0;
    @(negedge CLOCK_50);
    clr = 1'b1;
    model_reset();
    #2;
    checks++;
    if ({ev_valid, shift_held, caps_lock, overflow} !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid_flags got=%b exp=0000", {ev_valid, shift_held, caps_lock, overflow});
    end
    send_byte(8'h1C);
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL reset_evcount got=%0d exp=1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== tb_ev_t'({8'h1C, 1'b0, 1'b0, 8'h61})) begin
        failures++;
        $display("FAIL reset_event got=%h exp=%h", got_q[0], tb_ev_t'({8'h1C, 1'b0, 1'b0, 8'h61}));
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_shift();
    send_byte(8'h12);
    send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12);
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL shift_evcount got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL shift_event[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() >= 2) begin
      checks++;
      if (got_q[1].ascii !== 8'h41) begin
        failures++;
        $display("FAIL shift_upper_a got=%h exp=41", got_q[1].ascii);
      end
    end
    checks++;
    if (shift_held !== 1'b0) begin
      failures++;
      $display("FAIL shift_released got=%b exp=0", shift_held);
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_ext();
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL ext_evcount got=%0d exp=2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== tb_ev_t'({8'h75, 1'b0, 1'b1, 8'h00})) begin
        failures++;
        $display("FAIL ext_make got=%h exp=%h", got_q[0], tb_ev_t'({8'h75, 1'b0, 1'b1, 8'h00}));
      end
      checks++;
      if (got_q[1] !== exp_q[1]) begin
        failures++;
        $display("FAIL ext_break got=%h exp=%h", got_q[1], exp_q[1]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_caps();
    send_byte(8'h58);
    send_byte(8'h58);
    send_byte(8'hF0); send_byte(8'h58);
    #2;
    checks++;
    if (caps_lock !== 1'b1) begin
      failures++;
      $display("FAIL caps_toggle got=%b exp=1", caps_lock);
    end
    send_byte(8'h1C);
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if (got_q.size() != 4) begin
      failures++;
      $display("FAIL caps_evcount got=%0d exp=4", got_q.size());
    end else begin
      checks++;
      if (got_q[3].ascii !== 8'h41) begin
        failures++;
        $display("FAIL caps_upper_a got=%h exp=41", got_q[3].ascii);
      end
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL caps_event[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (seq[i]) send_byte(seq[i]);
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL pause_silent got=%0d exp=0", got_q.size());
    end
    send_byte(8'h16);
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL pause_evcount got=%0d exp=1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== tb_ev_t'({8'h16, 1'b0, 1'b0, 8'h31})) begin
        failures++;
        $display("FAIL pause_after got=%h exp=%h", got_q[0], tb_ev_t'({8'h16, 1'b0, 1'b0, 8'h31}));
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overflow();
    ev_ready = 1'b0;
    send_byte(8'h1C);
    send_byte(8'h32);
    #2;
    checks++;
    if ({ev_valid, ev_code, overflow} !== {1'b1, 8'h1C, 1'b1}) begin
      failures++;
      $display("FAIL ovf_hold got valid=%b code=%h ovf=%b exp valid=1 code=1c ovf=1",
               ev_valid, ev_code, overflow);
    end
    @(negedge CLOCK_50);
    code_in    = 8'h21;
    code_valid = 1'b1;
    ev_ready   = 1'b1;
    model_byte(8'h21);
    @(negedge CLOCK_50);
    code_valid = 1'b0;
    #2;
    checks++;
    if ({ev_valid, ev_code} !== {1'b1, 8'h21}) begin
      failures++;
      $display("FAIL ovf_accept_load got valid=%b code=%h exp valid=1 code=21", ev_valid, ev_code);
    end
    repeat (2) @(negedge CLOCK_50);
    #2;
    checks++;
    if ({ev_valid, overflow} !== 2'b01) begin
      failures++;
      $display("FAIL ovf_drain got valid=%b ovf=%b exp valid=0 ovf=1", ev_valid, overflow);
    end
    exp_q.delete(1);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL ovf_evcount got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ovf_event[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++)
      send_byte(POOL[$urandom_range(0, 23)]);
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_evcount got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rand_event[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({shift_held, caps_lock} !== {m_shl | m_shr, m_caps}) begin
      failures++;
      $display("FAIL rand_modifiers got shift=%b caps=%b exp shift=%b caps=%b",
               shift_held, caps_lock, m_shl | m_shr, m_caps);
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    clr        = 1'b0;
    code_in    = 8'h00;
    code_valid = 1'b0;
    ev_ready   = 1'b1;
    model_reset();
    test_reset();
    test_shift();
    test_ext();
    test_caps();
    test_pause();
    test_overflow();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
